// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: prefix-mask stalls from level requests and counted holds,
// a registered one-cycle prefix flush, and a saturating stall-cycle counter.
module pipe_stall_ctrl #(
  parameter int unsigned STAGES = 6,
  parameter int unsigned IDX_W  = $clog2(STAGES),
  parameter int unsigned HOLD_W = 6,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [STAGES-1:0] stall_req_i,
  input  logic              hold_start_i,
  input  logic [IDX_W-1:0]  hold_stage_i,
  input  logic [HOLD_W-1:0] hold_len_i,
  output logic              hold_busy_o,
  input  logic              flush_req_i,
  input  logic [IDX_W-1:0]  flush_stage_i,
  output logic [STAGES-1:0] stall_o,
  output logic [STAGES-1:0] flush_o,
  input  logic              clr_cnt_i,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic StIdle  = 1'b0;
  localparam logic StFlush = 1'b1;

  logic              state_q, state_d;
  logic [HOLD_W-1:0] hcnt_q, hcnt_d;
  logic [IDX_W-1:0]  hstg_q, hstg_d;
  logic [IDX_W-1:0]  fstg_q, fstg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [STAGES-1:0] req_mask, hold_mask, stall_int;
  logic              flush_blk, hold_acc;

  // Out-of-range indices naturally yield all-ones, which equals the clamped mask.
  function automatic logic [STAGES-1:0] prefix_mask(input logic [IDX_W-1:0] k);
    logic [STAGES-1:0] m;
    for (int i = 0; i < STAGES; i++) m[i] = (i <= int'(k));
    return m;
  endfunction

  function automatic logic [IDX_W-1:0] clamp_idx(input logic [IDX_W-1:0] k);
    return (int'(k) >= int'(STAGES)) ? IDX_W'(STAGES - 1) : k;
  endfunction

  always_comb begin
    // Bit i is set when any stage at or above i requests a stall.
    for (int i = 0; i < STAGES; i++) req_mask[i] = |(stall_req_i >> i);

    flush_blk = flush_req_i | (state_q == StFlush);
    hold_acc  = hold_start_i & (hold_len_i != '0) & (hcnt_q == '0) & ~flush_blk;

    if (hold_acc)            hold_mask = prefix_mask(hold_stage_i);
    else if (hcnt_q != '0)   hold_mask = prefix_mask(hstg_q);
    else                     hold_mask = '0;

    stall_int = (flush_blk | ~rst_n) ? '0 : (req_mask | hold_mask);
  end

  always_comb begin
    hcnt_d = hcnt_q;
    hstg_d = hstg_q;
    if (flush_req_i) begin
      hcnt_d = '0;
    end else if (hold_acc) begin
      hcnt_d = hold_len_i - HOLD_W'(1);
      hstg_d = clamp_idx(hold_stage_i);
    end else if (hcnt_q != '0) begin
      hcnt_d = hcnt_q - HOLD_W'(1);
    end

    state_d = flush_req_i ? StFlush : StIdle;
    fstg_d  = flush_req_i ? clamp_idx(flush_stage_i) : fstg_q;

    cnt_d = cnt_q;
    if (clr_cnt_i)                           cnt_d = '0;
    else if ((stall_int != '0) && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      hcnt_q  <= '0;
      hstg_q  <= '0;
      fstg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      hstg_q  <= hstg_d;
      fstg_q  <= fstg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_o     = stall_int;
  assign flush_o     = (state_q == StFlush) ? prefix_mask(fstg_q) : '0;
  assign hold_busy_o = (hcnt_q != '0);
  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed and randomized bench for pipe_stall_ctrl against an integer-level behavioural model;
// a second instance with a 4-bit counter exercises saturation.
module tb_pipe_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] stall_req;
  logic       hold_start;
  logic [2:0] hold_stage;
  logic [5:0] hold_len;
  logic       flush_req;
  logic [2:0] flush_stage;
  logic       clr_cnt;
  logic       busy_a, busy_b;
  logic [5:0] stall_a, flush_a, stall_b, flush_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  int n_chk = 0;
  int n_err = 0;

  // Model state, in terms of spec quantities.
  int m_hleft, m_hstg, m_fstg, m_cnt16, m_cnt4;
  bit m_fl;

  always #5 clk = ~clk;

  pipe_stall_ctrl dut (
    .clk(clk), .rst_n(rst_n), .stall_req_i(stall_req), .hold_start_i(hold_start),
    .hold_stage_i(hold_stage), .hold_len_i(hold_len), .hold_busy_o(busy_a),
    .flush_req_i(flush_req), .flush_stage_i(flush_stage), .stall_o(stall_a),
    .flush_o(flush_a), .clr_cnt_i(clr_cnt), .stall_cnt_o(cnt_a)
  );

  pipe_stall_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .stall_req_i(stall_req), .hold_start_i(hold_start),
    .hold_stage_i(hold_stage), .hold_len_i(hold_len), .hold_busy_o(busy_b),
    .flush_req_i(flush_req), .flush_stage_i(flush_stage), .stall_o(stall_b),
    .flush_o(flush_b), .clr_cnt_i(clr_cnt), .stall_cnt_o(cnt_b)
  );

  function automatic int clampi(input int k);
    return (k > 5) ? 5 : k;
  endfunction

  function automatic int pm(input int k);
    if (k < 0) return 0;
    return (1 << (clampi(k) + 1)) - 1;
  endfunction

  function automatic int hibit(input logic [5:0] r);
    for (int i = 5; i >= 0; i--) if (r[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hleft = 0; m_hstg = 0; m_fstg = 0; m_cnt16 = 0; m_cnt4 = 0; m_fl = 0;
  endtask

  // One clock cycle: drive at negedge, check mid-low-phase, advance model at posedge.
  // want_stall / want_flush of -1 means no literal expectation for this step.
  task automatic step(input string tag, input logic [5:0] req, input bit hs, input int hstage,
                      input int hlen, input bit fr, input int fstage, input bit clr,
                      input int want_stall, input int want_flush);
    bit accept, blk;
    int kh, kmax, e_stall;
    stall_req = req; hold_start = hs; hold_stage = 3'(hstage); hold_len = 6'(hlen);
    flush_req = fr; flush_stage = 3'(fstage); clr_cnt = clr;
    #1;
    blk    = fr || m_fl;
    accept = hs && (hlen != 0) && (m_hleft == 0) && !blk;
    kh     = accept ? clampi(hstage) : ((m_hleft > 0) ? m_hstg : -1);
    kmax   = (hibit(req) > kh) ? hibit(req) : kh;
    e_stall = blk ? 0 : pm(kmax);
    chk({tag, ".stall"}, 32'(stall_a), 32'(e_stall));
    chk({tag, ".flush"}, 32'(flush_a), 32'(m_fl ? pm(m_fstg) : 0));
    chk({tag, ".busy"}, 32'(busy_a), 32'(m_hleft > 0));
    chk({tag, ".cnt16"}, 32'(cnt_a), 32'(m_cnt16));
    chk({tag, ".cnt4"}, 32'(cnt_b), 32'(m_cnt4));
    chk({tag, ".stall4"}, 32'(stall_b), 32'(e_stall));
    if (want_stall >= 0) chk({tag, ".stall_lit"}, 32'(stall_a), 32'(want_stall));
    if (want_flush >= 0) chk({tag, ".flush_lit"}, 32'(flush_a), 32'(want_flush));
    @(posedge clk);
    if (clr) begin
      m_cnt16 = 0; m_cnt4 = 0;
    end else if (e_stall != 0) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    if (fr) m_hleft = 0;
    else if (accept) begin m_hleft = hlen - 1; m_hstg = clampi(hstage); end
    else if (m_hleft > 0) m_hleft--;
    m_fl = fr;
    if (fr) m_fstg = clampi(fstage);
    @(negedge clk);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 6'b0, 0, 0, 0, 0, 0, 0, -1, -1);
  endtask

  initial begin
    rst_n = 1'b0; stall_req = '0; hold_start = 0; hold_stage = '0; hold_len = '0;
    flush_req = 0; flush_stage = '0; clr_cnt = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst.stall", 32'(stall_a), 0);
    chk("rst.flush", 32'(flush_a), 0);
    chk("rst.busy", 32'(busy_a), 0);
    chk("rst.cnt", 32'(cnt_a), 0);
    rst_n = 1'b1;

    // Level requests.
    step("req_ex", 6'b001000, 0, 0, 0, 0, 0, 0, 6'b001111, 0);
    step("req_id", 6'b000100, 0, 0, 0, 0, 0, 0, 6'b000111, 0);
    step("req_idex", 6'b001100, 0, 0, 0, 0, 0, 0, 6'b001111, 0);
    step("req_none", 6'b000000, 0, 0, 0, 0, 0, 0, 0, 0);

    // Counted hold of 4, with an ignored second start in cycle 2.
    step("hold_c1", 6'b0, 1, 3, 4, 0, 0, 0, 6'b001111, -1);
    chk("hold_busy_c2", 32'(busy_a), 1);
    step("hold_c2", 6'b0, 1, 5, 9, 0, 0, 0, 6'b001111, -1);
    step("hold_c3", 6'b0, 0, 0, 0, 0, 0, 0, 6'b001111, -1);
    step("hold_c4", 6'b0, 0, 0, 0, 0, 0, 0, 6'b001111, -1);
    step("hold_end", 6'b0, 0, 0, 0, 0, 0, 0, 0, -1);
    chk("hold_busy_end", 32'(busy_a), 0);

    // Hold merged with a one-cycle request.
    step("merge_c1", 6'b010000, 1, 1, 3, 0, 0, 0, 6'b011111, -1);
    step("merge_c2", 6'b0, 0, 0, 0, 0, 0, 0, 6'b000011, -1);
    step("merge_c3", 6'b0, 0, 0, 0, 0, 0, 0, 6'b000011, -1);
    step("merge_end", 6'b0, 0, 0, 0, 0, 0, 0, 0, -1);

    // Flush cancelling a hold at hcnt=5; then back-to-back flushes incl. clamp.
    step("fh_acc", 6'b0, 1, 2, 7, 0, 0, 0, 6'b000111, -1);
    step("fh_c2", 6'b0, 0, 0, 0, 0, 0, 0, 6'b000111, -1);
    step("fh_req", 6'b000100, 0, 0, 0, 1, 4, 0, 0, 0);
    step("fh_fl", 6'b0, 1, 3, 5, 0, 0, 0, 0, 6'b011111);
    chk("fh_busy", 32'(busy_a), 0);
    step("fh_after", 6'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("bb_req1", 6'b0, 0, 0, 0, 1, 1, 0, 0, 0);
    step("bb_req2", 6'b0, 0, 0, 0, 1, 7, 0, 0, 6'b000011);
    step("bb_fl2", 6'b0, 0, 0, 0, 0, 0, 0, 0, 6'b111111);
    step("bb_done", 6'b0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Counter: clear, 10 stalls, clear, 20 stalls for saturation of the 4-bit instance.
    step("cnt_clr", 6'b0, 0, 0, 0, 0, 0, 1, -1, -1);
    chk("cnt_clr0", 32'(cnt_a), 0);
    for (int i = 0; i < 10; i++) step("cnt_run", 6'b000001, 0, 0, 0, 0, 0, 0, 1, -1);
    chk("cnt_ten", 32'(cnt_a), 10);
    step("cnt_clr2", 6'b000001, 0, 0, 0, 0, 0, 1, 1, -1);
    chk("cnt_clr_pri", 32'(cnt_a), 0);
    for (int i = 0; i < 20; i++) step("cnt_sat", 6'b000010, 0, 0, 0, 0, 0, 0, 3, -1);
    chk("cnt_sat4", 32'(cnt_b), 15);
    chk("cnt_twenty", 32'(cnt_a), 20);

    // Reset mid-hold (hcnt=3) with a flush pending.
    step("rh_acc", 6'b0, 1, 3, 8, 0, 0, 0, 6'b001111, -1);
    idle("rh_run", 4);
    stall_req = 6'b100000; flush_req = 1; flush_stage = 3'd5;
    #1;
    rst_n = 1'b0;
    #1;
    chk("rh.stall", 32'(stall_a), 0);
    chk("rh.flush", 32'(flush_a), 0);
    chk("rh.busy", 32'(busy_a), 0);
    chk("rh.cnt", 32'(cnt_a), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    stall_req = '0; flush_req = 0;
    rst_n = 1'b1;
    step("rh_post1", 6'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rh_post2", 6'b0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [5:0] r;
      int hl;
      r  = ($urandom_range(0, 1) == 0) ? 6'b0 : 6'($urandom);
      hl = ($urandom_range(0, 15) == 0) ? 63 : int'($urandom_range(0, 7));
      step("rnd", r, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)), hl,
           ($urandom_range(0, 9) == 0), int'($urandom_range(0, 7)),
           ($urandom_range(0, 39) == 0), -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
